instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch stage of the RISC-V core: owns the program counter and drives the word address of the combinational 64×32 instruction memory. It samples the returned instruction into the IF/ID pipeline register for decode. It handles stall, branch/jump redirect, flush bubbles and a halt state.

## Interface

Parameters:
- `IMEM_AW`, default 6: instruction-memory word-address width (64 words).
- `RESET_PC`, default 32'h00000000: byte address fetched after reset.
- `NOP_INSTR`, default 32'h00000013: bubble encoding (`addi x0,x0,0`).
- `HALT_INSTR`, default 32'h00000073: `ecall`; fetching it halts the stage.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard unit holds PC and IF/ID.
- `redirect` in 1: taken branch or jump from EX.
- `redirect_pc` in 32: byte target for `redirect`.
- `imem_addr` out `IMEM_AW`: word address to instruction memory, equal to `pc[IMEM_AW+1:2]`.
- `imem_instr` in 32: instruction read combinationally from `imem_addr`.
- `pc` out 32: current fetch PC.
- `if_id_pc` out 32: PC of the registered instruction.
- `if_id_instr` out 32: registered instruction.
- `if_id_valid` out 1: `if_id_instr` is a real instruction, not a bubble.
- `halted` out 1: stage is in HALT.
- `fetch_count` out 16: number of valid instructions delivered to IF/ID.

## Operation

The stage has three states.
- **BOOT**
  - Entered on reset.
  - Lasts exactly one cycle: IF/ID holds a bubble and `pc` = `RESET_PC`.
  - Then goes to RUN unconditionally, unless `reset` is still high.
- **RUN**, on each edge, in priority order:
  - `reset`: go to BOOT.
  - `redirect`:
    - `pc` ← `{redirect_pc[31:2],2'b00}`.
    - IF/ID ← bubble (`NOP_INSTR`, `if_id_valid`=0, `if_id_pc` ← 0).
    - `redirect` overrides a simultaneous `stall`.
  - `stall`: `pc`, IF/ID and `fetch_count` all hold.
  - Otherwise:
    - IF/ID ← {`pc`, `imem_instr`, valid=1}.
    - `pc` ← `pc`+4.
    - `fetch_count` += 1.
    - If `imem_instr` == `HALT_INSTR`, the instruction is still latched valid and the next state is HALT.
- **HALT**
  - `pc` and `fetch_count` are frozen.
  - Following that, IF/ID ← bubble.
  - `redirect` returns to RUN, loading `redirect_pc` exactly as in RUN; `stall` is ignored.
  - Only `reset` or `redirect` leave HALT.

Arithmetic and width rules:
- `pc` is 32 bits and `pc`+4 wraps modulo 2^32.
- `imem_addr` uses only `pc[IMEM_AW+1:2]`, so byte address 0x100 reads word 0. This aliasing is the required behaviour; no error is flagged.
- `redirect_pc[1:0]` are discarded.
- `fetch_count` wraps 0xFFFF → 0x0000.

Reset values, all outputs:
- `pc` = `RESET_PC`
- `imem_addr` = `RESET_PC[IMEM_AW+1:2]`
- `if_id_pc` = 0
- `if_id_instr` = `NOP_INSTR`
- `if_id_valid` = 0
- `halted` = 0
- `fetch_count` = 0

## Timing

- Memory read is combinational: `imem_instr` must settle within the same cycle from `imem_addr`.
- Fetch latency: the instruction at `pc` appears on `if_id_*` one cycle after the edge at which `pc` is presented and not stalled.
- Redirect:
  - Asserting `redirect` in cycle N makes `pc` = target in N+1.
  - The IF/ID bubble appears in N+1.
  - The target instruction appears in IF/ID in N+2.
- `stall` is level-sensitive and must be held for as many cycles as the hold is needed; releasing it resumes fetch on the next edge with no lost or duplicated instruction.
- `halted` rises the cycle after the `HALT_INSTR` edge.
- Reset mid-operation discards any pending stall, redirect or HALT. The first valid fetch after deassertion (from `RESET_PC`) occurs at the second edge after deassertion, because of BOOT.

## Structure

- Shared package `riscv_pkg` holds:
  - the state enum (BOOT/RUN/HALT);
  - `NOP_INSTR` and `HALT_INSTR` encodings;
  - `XLEN`=32.
- Natural sub-module `if_id_reg`: the IF/ID register with load, hold and bubble controls, reused by the decode stage's own tests.
- The PC/FSM logic stays in the top.
- The memory itself stays external.

## Test plan

- Reset, then 10 free-running cycles from the 21-word program: `if_id_pc` steps 0,4,8,… and `if_id_instr` at PC 0x8 = 32'h00100093; `fetch_count`=9 after the cycle in which `if_id_pc`=0x20.
- `stall` high for 3 cycles while `pc`=0x10: IF/ID holds 32'h00200113 with PC 0xC; after release the next instruction is 32'h00308193 and nothing is skipped.
- `redirect` to 0x4E (masked to 0x4C) with `stall` also high: next cycle `pc`=0x4C and a bubble (valid=0); the following cycle IF/ID = 32'h02B02823.
- Word 5 loaded with 32'h00000073 and fetched: it is latched valid, `halted`=1 next cycle, then bubbles with `pc` frozen; `redirect` to 0 resumes fetch.
- PC walked to 0xFC: the next fetch uses `imem_addr`=0 (aliases to word 0) and `pc`=0x100.
- `reset` asserted mid-run with `fetch_count`=7: next cycle all outputs are at reset values; first valid IF/ID is PC 0 two edges after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core pipeline stages.
package riscv_pkg;

   localparam int XLEN = 32;

   // addi x0,x0,0 is used as the pipeline bubble; ecall stops fetch.
   localparam logic [XLEN-1:0] RV_NOP_INSTR  = 32'h0000_0013;
   localparam logic [XLEN-1:0] RV_HALT_INSTR = 32'h0000_0073;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold it, or insert a bubble.
module if_id_reg
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            bubble,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] instr_in,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] instr,
   output logic            valid
);

   // Bubble wins over load; with neither asserted the register holds.
   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         pc    <= '0;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (load) begin
         pc    <= pc_in;
         instr <= instr_in;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: program counter, BOOT/RUN/HALT sequencing and the IF/ID register.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_BOOT | one cycle after reset; pc = RESET_PC, IF/ID holds a bubble
//   S_RUN  | fetching; redirect > stall > sequential fetch
//   S_HALT | ecall was fetched; pc and count frozen, IF/ID bubbles
//          | until redirect (or reset)
module instruction_fetch_stage
   import riscv_pkg::*;
#(
   parameter int              IMEM_AW    = 6,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR  = RV_NOP_INSTR,
   parameter logic [XLEN-1:0] HALT_INSTR = RV_HALT_INSTR
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               redirect,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [XLEN-1:0]    imem_instr,
   output logic [XLEN-1:0]    pc,
   output logic [XLEN-1:0]    if_id_pc,
   output logic [XLEN-1:0]    if_id_instr,
   output logic               if_id_valid,
   output logic               halted,
   output logic [15:0]        fetch_count
);

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc_nxt;
   logic [XLEN-1:0] target_pc;
   logic            do_fetch;
   logic            do_bubble;
   logic            unused_bits;

   // Word-aligned redirect target; the low two bits carry no meaning.
   assign target_pc   = {redirect_pc[XLEN-1:2], 2'b00};
   assign unused_bits = ^redirect_pc[1:0];

   // Memory is word addressed and deliberately aliases above its size.
   assign imem_addr = pc[IMEM_AW+1:2];
   assign halted    = (state == S_HALT);

   // Next-state, next-pc and IF/ID control decode.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      do_fetch  = 1'b0;
      do_bubble = 1'b0;
      case (state)
         S_BOOT: begin
            state_nxt = S_RUN;
            do_bubble = 1'b1;
         end
         S_RUN: begin
            if (redirect) begin
               pc_nxt    = target_pc;
               do_bubble = 1'b1;
            end else if (!stall) begin
               do_fetch = 1'b1;
               pc_nxt   = pc + 32'd4;
               if (imem_instr == HALT_INSTR) begin
                  state_nxt = S_HALT;
               end
            end
         end
         S_HALT: begin
            do_bubble = 1'b1;
            if (redirect) begin
               pc_nxt    = target_pc;
               state_nxt = S_RUN;
            end
         end
         default: begin
            state_nxt = S_BOOT;
            do_bubble = 1'b1;
         end
      endcase
   end

   // PC, state and delivered-instruction counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_BOOT;
         pc          <= RESET_PC;
         fetch_count <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (do_fetch) begin
            fetch_count <= fetch_count + 16'd1;
         end
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk      (clk),
      .reset    (reset),
      .load     (do_fetch),
      .bubble   (do_bubble),
      .pc_in    (pc),
      .instr_in (imem_instr),
      .pc       (if_id_pc),
      .instr    (if_id_instr),
      .valid    (if_id_valid)
   );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for the fetch stage with a 64-word combinational program memory.
module tb_instruction_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [5:0]  imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] pc;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        halted;
   logic [15:0] fetch_count;

   logic [31:0] mem [64];
   int          n_chk;
   int          n_pass;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] ECALL = 32'h0000_0073;

   instruction_fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .pc          (pc),
      .if_id_pc    (if_id_pc),
      .if_id_instr (if_id_instr),
      .if_id_valid (if_id_valid),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   assign imem_instr = mem[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      reset = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      for (int i = 0; i < 64; i++) mem[i] = NOP;
      mem[0]  = 32'h00000033;  mem[1]  = 32'h00000093;
      mem[2]  = 32'h00100093;  mem[3]  = 32'h00200113;
      mem[4]  = 32'h00308193;  mem[5]  = 32'h00408213;
      mem[6]  = 32'h00510293;  mem[7]  = 32'h00618313;
      mem[8]  = 32'h00720393;  mem[9]  = 32'h00828413;
      mem[10] = 32'h00930493;  mem[11] = 32'h00a38513;
      mem[12] = 32'h00b40593;  mem[13] = 32'h00c48613;
      mem[14] = 32'h00d50693;  mem[15] = 32'h00e58713;
      mem[16] = 32'h00f60793;  mem[17] = 32'h01068813;
      mem[18] = 32'h01170893;  mem[19] = 32'h02B02823;
      mem[20] = 32'h0000006f;

      // Reset values
      tick();
      tick();
      chk("rst_pc", pc, 32'h0);
      chk("rst_addr", {26'd0, imem_addr}, 32'h0);
      chk("rst_ifpc", if_id_pc, 32'h0);
      chk("rst_instr", if_id_instr, NOP);
      chk("rst_valid", {31'd0, if_id_valid}, 32'h0);
      chk("rst_halted", {31'd0, halted}, 32'h0);
      chk("rst_count", {16'd0, fetch_count}, 32'h0);

      // BOOT cycle, then free-running fetch
      reset = 1'b0;
      tick();
      chk("boot_valid", {31'd0, if_id_valid}, 32'h0);
      chk("boot_pc", pc, 32'h0);
      for (int k = 0; k < 9; k++) begin
         tick();
         chk("run_ifpc", if_id_pc, 32'(4 * k));
         chk("run_instr", if_id_instr, mem[k]);
         chk("run_valid", {31'd0, if_id_valid}, 32'h1);
         chk("run_count", {16'd0, fetch_count}, 32'(k + 1));
      end
      chk("run_pc", pc, 32'h24);

      // Stall for three cycles with pc = 0x10
      do_reset();
      for (int k = 0; k < 4; k++) tick();
      chk("pre_stall_pc", pc, 32'h10);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_instr", if_id_instr, 32'h00200113);
         chk("stall_ifpc", if_id_pc, 32'hC);
         chk("stall_pc", pc, 32'h10);
         chk("stall_count", {16'd0, fetch_count}, 32'd4);
      end
      stall = 1'b0;
      tick();
      chk("unstall_instr", if_id_instr, 32'h00308193);
      chk("unstall_ifpc", if_id_pc, 32'h10);
      chk("unstall_count", {16'd0, fetch_count}, 32'd5);

      // Redirect beats a simultaneous stall; target low bits dropped
      stall = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h4E;
      tick();
      stall = 1'b0;
      redirect = 1'b0;
      chk("redir_pc", pc, 32'h4C);
      chk("redir_addr", {26'd0, imem_addr}, 32'd19);
      chk("redir_valid", {31'd0, if_id_valid}, 32'h0);
      chk("redir_ifpc", if_id_pc, 32'h0);
      chk("redir_count", {16'd0, fetch_count}, 32'd5);
      tick();
      chk("redir_tgt_instr", if_id_instr, 32'h02B02823);
      chk("redir_tgt_ifpc", if_id_pc, 32'h4C);
      chk("redir_tgt_valid", {31'd0, if_id_valid}, 32'h1);

      // Halt on ecall at word 5
      mem[5] = ECALL;
      do_reset();
      for (int k = 0; k < 6; k++) tick();
      chk("halt_instr", if_id_instr, ECALL);
      chk("halt_valid", {31'd0, if_id_valid}, 32'h1);
      chk("halt_ifpc", if_id_pc, 32'h14);
      chk("halt_flag", {31'd0, halted}, 32'h1);
      chk("halt_pc", pc, 32'h18);
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("halted_valid", {31'd0, if_id_valid}, 32'h0);
         chk("halted_instr", if_id_instr, NOP);
         chk("halted_pc", pc, 32'h18);
         chk("halted_count", {16'd0, fetch_count}, 32'd6);
         chk("halted_flag", {31'd0, halted}, 32'h1);
      end
      stall = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h0;
      tick();
      redirect = 1'b0;
      chk("resume_pc", pc, 32'h0);
      chk("resume_flag", {31'd0, halted}, 32'h0);
      chk("resume_valid", {31'd0, if_id_valid}, 32'h0);
      tick();
      chk("resume_instr", if_id_instr, mem[0]);
      chk("resume_fetch_valid", {31'd0, if_id_valid}, 32'h1);
      chk("resume_count", {16'd0, fetch_count}, 32'd7);
      mem[5] = 32'h00408213;

      // Address aliasing at the top of the memory
      redirect = 1'b1;
      redirect_pc = 32'hFC;
      tick();
      redirect = 1'b0;
      chk("walk_pc", pc, 32'hFC);
      chk("walk_addr", {26'd0, imem_addr}, 32'd63);
      tick();
      chk("walk_ifpc", if_id_pc, 32'hFC);
      chk("walk_instr", if_id_instr, NOP);
      chk("wrap_pc", pc, 32'h100);
      chk("wrap_addr", {26'd0, imem_addr}, 32'd0);
      tick();
      chk("alias_ifpc", if_id_pc, 32'h100);
      chk("alias_instr", if_id_instr, mem[0]);

      // 32-bit pc wrap
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect = 1'b0;
      chk("top_pc", pc, 32'hFFFF_FFFC);
      tick();
      chk("pc_wrap", pc, 32'h0);
      chk("pc_wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);

      // Reset mid-run with fetch_count = 7
      do_reset();
      for (int k = 0; k < 7; k++) tick();
      chk("mid_count", {16'd0, fetch_count}, 32'd7);
      stall = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h40;
      reset = 1'b1;
      tick();
      stall = 1'b0;
      redirect = 1'b0;
      chk("mrst_pc", pc, 32'h0);
      chk("mrst_ifpc", if_id_pc, 32'h0);
      chk("mrst_instr", if_id_instr, NOP);
      chk("mrst_valid", {31'd0, if_id_valid}, 32'h0);
      chk("mrst_count", {16'd0, fetch_count}, 32'h0);
      chk("mrst_halted", {31'd0, halted}, 32'h0);
      reset = 1'b0;
      tick();
      chk("mrst_boot_valid", {31'd0, if_id_valid}, 32'h0);
      tick();
      chk("mrst_first_valid", {31'd0, if_id_valid}, 32'h1);
      chk("mrst_first_ifpc", if_id_pc, 32'h0);
      chk("mrst_first_instr", if_id_instr, mem[0]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
